// File: rtl/subslot_expander_n_pkg.sv
// Shared types and constants for the MSX subslot expander.
// Optional feature macro used by the top: SUBSLOT_EXPANDER_WRCNT_EN.
package msx_subslot_pkg;

  // Per-slot access mode as presented on slot_mode.
  typedef enum logic [1:0] {
    SS_OFF    = 2'd0,
    SS_EXP    = 2'd1,
    SS_EXP_WO = 2'd2,
    SS_RSVD   = 2'd3
  } subslot_mode_t;

  // Bus access FSM states.
  typedef enum logic [1:0] {
    SS_IDLE   = 2'd0,
    SS_RD_ACT = 2'd1,
    SS_HOLD   = 2'd2
  } subslot_state_t;

  // Conventional MSX location of the secondary-slot register.
  localparam logic [15:0] SUBSLOT_REG_DEFAULT = 16'hFFFF;

  // The reserved mode code behaves exactly like a plain expanded slot.
  function automatic subslot_mode_t fold_mode(input logic [1:0] raw);
    subslot_mode_t m;
    if (raw == 2'd3) m = SS_EXP;
    else             m = subslot_mode_t'(raw);
    return m;
  endfunction

endpackage

// File: rtl/subslot_expander_n_if.sv
// CPU-side bus bundle seen by the subslot expander.
// master = CPU / bus driver, slave = expander.
interface subslot_expander_n_if;

  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        mreq;
  logic        rd;
  logic        wr;
  logic        req;
  logic [7:0]  data;
  logic        output_rq;

  modport master (
    output addr, data_in, mreq, rd, wr, req,
    input  data, output_rq
  );

  modport slave (
    input  addr, data_in, mreq, rd, wr, req,
    output data, output_rq
  );

endinterface

// File: rtl/subslot_expander_n.sv
// Parametrised MSX secondary-slot expander: one subslot select register per
// primary slot, a one-write-per-access FSM, a registered read path and a
// write-notify strobe for downstream mapper/cache logic.
// Optional: define SUBSLOT_EXPANDER_WRCNT_EN to add saturating per-slot
// write counters on the wr_count port.
module subslot_expander_n
  import msx_subslot_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter int          SLOT_W      = $clog2(NUM_SLOTS),
  parameter logic [15:0] REG_ADDR    = SUBSLOT_REG_DEFAULT,
  parameter bit          INVERT_READ = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  subslot_expander_n_if.slave    bus,
  input  logic [SLOT_W-1:0]      active_slot,
  input  logic [2*NUM_SLOTS-1:0] slot_mode,
  input  logic [8*NUM_SLOTS-1:0] slot_init,
  input  logic                   expander_force_en,
  output logic [1:0]             active_subslot,
  output logic                   wr_pulse,
  output logic [SLOT_W-1:0]      wr_slot
`ifdef SUBSLOT_EXPANDER_WRCNT_EN
  ,
  output logic [8*NUM_SLOTS-1:0] wr_count
`endif
);

  subslot_mode_t     em;
  logic              cs;
  logic              wr_accept;
  logic              rd_accept;
  logic [7:0]        sub_reg [NUM_SLOTS];
  logic [7:0]        cur_reg;
  logic [7:0]        read_value;
  subslot_state_t    state_reg;
  logic [7:0]        data_q_reg;
  logic              wr_pulse_reg;
  logic [SLOT_W-1:0] wr_slot_reg;

  // Effective mode of the selected slot, chip select and accept conditions.
  // Writes are only taken from IDLE so a held request writes exactly once,
  // and a write in the same cycle as a read suppresses the read claim.
  always_comb begin
    em         = expander_force_en ? SS_EXP
                                   : fold_mode(slot_mode[{active_slot, 1'b0} +: 2]);
    cs         = (bus.addr == REG_ADDR) && bus.mreq && (em != SS_OFF);
    wr_accept  = (state_reg == SS_IDLE) && cs && bus.wr && bus.req;
    rd_accept  = (state_reg == SS_IDLE) && cs && bus.rd &&
                 (em != SS_EXP_WO) && !wr_accept;
    cur_reg    = sub_reg[active_slot];
    read_value = INVERT_READ ? ~cur_reg : cur_reg;
  end

  // Register file: one subslot select byte per primary slot.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [7:0] slot_reg;

    // Load the per-slot init value on reset, otherwise take accepted writes.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg <= slot_init[8*gi +: 8];
      end else if (wr_accept && (active_slot == SLOT_W'(gi))) begin
        slot_reg <= bus.data_in;
      end
    end

    assign sub_reg[gi] = slot_reg;
  end

  // Access FSM with the read latch and write-notify registers.
  // Read data is captured once on entry to RD_ACT, so a change of
  // active_slot mid-access does not retarget the returned value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SS_IDLE;
      data_q_reg   <= 8'hFF;
      wr_pulse_reg <= 1'b0;
      wr_slot_reg  <= '0;
    end else begin
      wr_pulse_reg <= 1'b0;
      case (state_reg)
        SS_IDLE: begin
          if (wr_accept) begin
            state_reg    <= SS_HOLD;
            wr_pulse_reg <= 1'b1;
            wr_slot_reg  <= active_slot;
          end else if (rd_accept) begin
            state_reg  <= SS_RD_ACT;
            data_q_reg <= read_value;
          end
        end
        SS_RD_ACT: begin
          if (!(cs && bus.rd)) state_reg <= SS_IDLE;
        end
        SS_HOLD: begin
          if (!(cs && (bus.wr || bus.rd))) state_reg <= SS_IDLE;
        end
        default: state_reg <= SS_IDLE;
      endcase
    end
  end

  // The bus only sees the latched byte while the read is being claimed.
  assign bus.output_rq = (state_reg == SS_RD_ACT);
  assign bus.data      = (state_reg == SS_RD_ACT) ? data_q_reg : 8'hFF;
  assign wr_pulse      = wr_pulse_reg;
  assign wr_slot       = wr_slot_reg;

  // Page-select mux: addr[15:14] picks the 2-bit field of the current slot.
  assign active_subslot = (em == SS_OFF) ? 2'b00
                                         : cur_reg[{bus.addr[15:14], 1'b0} +: 2];

`ifdef SUBSLOT_EXPANDER_WRCNT_EN
  // Saturating count of accepted writes per slot.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_wrcnt
    logic [7:0] cnt_reg;

    // Increment on an accepted write to this slot, holding at 8'hFF.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= 8'h00;
      end else if (wr_accept && (active_slot == SLOT_W'(gi)) && (cnt_reg != 8'hFF)) begin
        cnt_reg <= cnt_reg + 8'h01;
      end
    end

    assign wr_count[8*gi +: 8] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_subslot_expander_n.sv
// Scoreboard bench for subslot_expander_n (NUM_SLOTS = 4, INVERT_READ = 1).
// Stimulus pushes expected read data / write slots into queues; a monitor
// pops and compares whenever the DUT claims a read or pulses wr_pulse.
module tb_subslot_expander_n;
  import msx_subslot_pkg::*;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  active_slot;
  logic [7:0]  slot_mode;
  logic [31:0] slot_init;
  logic        force_en;
  logic [1:0]  active_subslot;
  logic        wr_pulse;
  logic [1:0]  wr_slot;
`ifdef SUBSLOT_EXPANDER_WRCNT_EN
  logic [31:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] model_reg [NS];
  logic [7:0] rd_q [$];
  logic [1:0] wr_q [$];

  subslot_expander_n_if bus ();

  subslot_expander_n #(
    .NUM_SLOTS   (NS),
    .REG_ADDR    (16'hFFFF),
    .INVERT_READ (1'b1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .active_slot       (active_slot),
    .slot_mode         (slot_mode),
    .slot_init         (slot_init),
    .expander_force_en (force_en),
    .active_subslot    (active_subslot),
    .wr_pulse          (wr_pulse),
    .wr_slot           (wr_slot)
`ifdef SUBSLOT_EXPANDER_WRCNT_EN
    ,
    .wr_count          (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Effective mode from the behavioural rules: force wins, code 3 acts as 1.
  function automatic int eff_mode(input int s);
    int m;
    if (force_en) return 1;
    m = int'((slot_mode >> (2 * s)) & 8'h03);
    if (m == 3) m = 1;
    return m;
  endfunction

  function automatic logic [1:0] exp_subslot(input int s, input logic [15:0] a);
    logic [1:0] page;
    page = a[15:14];
    if (eff_mode(s) == 0) return 2'b00;
    return 2'((model_reg[s] >> (2 * page)) & 8'h03);
  endfunction

  // Monitor: compare every claimed read and every write strobe.
  always @(negedge clk) begin
    if (bus.output_rq === 1'b1) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_claim: got unexpected claim data=%h expected no claim", bus.data);
      end else begin
        check("rd_data", 32'(bus.data), 32'(rd_q.pop_front()));
      end
    end
    if (wr_pulse === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_pulse: got unexpected pulse slot=%0d expected none", wr_slot);
      end else begin
        check("wr_slot", 32'(wr_slot), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic idle_bus();
    bus.addr    = 16'h0000;
    bus.data_in = 8'h00;
    bus.mreq    = 1'b0;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.req     = 1'b0;
  endtask

  task automatic load_model(input logic [31:0] init);
    for (int i = 0; i < NS; i++) model_reg[i] = init[8*i +: 8];
  endtask

  task automatic do_reset(input logic [31:0] init);
    slot_init = init;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load_model(init);
    $display("reset init=%h", init);
  endtask

  // Each access task starts and ends at posedge+1 with an idle bus.
  task automatic do_write(input int s, input logic [7:0] d, input logic [15:0] a);
    bit acc;
    acc = (a == 16'hFFFF) && (eff_mode(s) != 0);
    active_slot = 2'(s);
    bus.addr = a; bus.data_in = d; bus.mreq = 1'b1; bus.wr = 1'b1; bus.req = 1'b1;
    if (acc) begin
      wr_q.push_back(2'(s));
      model_reg[s] = d;
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    $display("write slot=%0d addr=%h data=%h accepted=%0d", s, a, d, acc);
  endtask

  task automatic do_read(input int s, input logic [15:0] a);
    bit claim;
    int m;
    m = eff_mode(s);
    claim = (a == 16'hFFFF) && (m != 0) && (m != 2);
    active_slot = 2'(s);
    bus.addr = a; bus.mreq = 1'b1; bus.rd = 1'b1; bus.req = 1'b1;
    if (claim) rd_q.push_back(~model_reg[s]);
    @(posedge clk); #1;
    if (!claim) begin
      #4;
      check("no_claim_rq", 32'(bus.output_rq), 32'd0);
      check("no_claim_data", 32'(bus.data), 32'hFF);
      #1;
    end
    idle_bus();
    @(posedge clk); #1;
    $display("read slot=%0d addr=%h claim=%0d", s, a, claim);
  endtask

  task automatic check_subslot(input int s, input logic [15:0] a);
    active_slot = 2'(s);
    bus.addr = a;
    #1;
    check("active_subslot", 32'(active_subslot), 32'(exp_subslot(s, a)));
    $display("subslot slot=%0d addr=%h value=%0d", s, a, active_subslot);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1;
    active_slot = 2'd0;
    slot_mode = 8'b01_01_01_01;
    force_en = 1'b0;
    slot_init = {8'hE4, 8'h00, 8'hAA, 8'h55};
    idle_bus();
    @(posedge clk); #1;
    reset = 1'b0;
    load_model(slot_init);

    // Reset state.
    check("rst_data", 32'(bus.data), 32'hFF);
    check("rst_rq", 32'(bus.output_rq), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_slot", 32'(wr_slot), 32'd0);
    do_read(0, 16'hFFFF);                       // expect ~55 = AA

    // Write and page decode.
    do_write(2, 8'h1B, 16'hFFFF);
    check_subslot(2, 16'h4000);                 // expect 2
    check_subslot(2, 16'hC000);                 // expect 0
    check("decode_4000", 32'(exp_subslot(2, 16'h4000)), 32'd2);

    // Held write: data changes after the first cycle, only one write lands.
    active_slot = 2'd0;
    bus.addr = 16'hFFFF; bus.data_in = 8'h33; bus.mreq = 1'b1; bus.wr = 1'b1; bus.req = 1'b1;
    wr_q.push_back(2'd0);
    model_reg[0] = 8'h33;
    @(posedge clk); #1;
    bus.data_in = 8'h44;
    repeat (4) begin @(posedge clk); #1; end
    idle_bus();
    @(posedge clk); #1;
    $display("held write slot=0 data=33 then 44");
    do_read(0, 16'hFFFF);                       // expect CC

    // Mode gating.
    slot_mode[3:2] = 2'd0;
    do_write(1, 8'h5A, 16'hFFFF);               // ignored
    check_subslot(1, 16'h4000);                 // expect 0
    force_en = 1'b1;
    do_write(1, 8'h5A, 16'hFFFF);               // accepted
    check_subslot(1, 16'h4000);                 // 5A -> page1 = 2
    do_read(1, 16'hFFFF);
    force_en = 1'b0;
    slot_mode[5:4] = 2'd2;
    do_read(2, 16'hFFFF);                       // write-only: no claim
    do_write(2, 8'h77, 16'hFFFF);               // still accepted
    slot_mode[5:4] = 2'd3;
    do_read(2, 16'hFFFF);                       // code 3 claims like 1

    // Write beats read in the same cycle.
    active_slot = 2'd3;
    bus.addr = 16'hFFFF; bus.data_in = 8'h9C; bus.mreq = 1'b1;
    bus.rd = 1'b1; bus.wr = 1'b1; bus.req = 1'b1;
    wr_q.push_back(2'd3);
    model_reg[3] = 8'h9C;
    @(posedge clk); #5;
    check("wr_beats_rd_rq", 32'(bus.output_rq), 32'd0);
    #1;
    idle_bus();
    @(posedge clk); #1;
    $display("read+write slot=3 data=9C");
    do_read(3, 16'hFFFF);

    // Reset in the middle of a read.
    active_slot = 2'd0;
    bus.addr = 16'hFFFF; bus.mreq = 1'b1; bus.rd = 1'b1; bus.req = 1'b1;
    rd_q.push_back(~model_reg[0]);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load_model(slot_init);
    check("midrd_rst_rq", 32'(bus.output_rq), 32'd0);
    check("midrd_rst_data", 32'(bus.data), 32'hFF);
    idle_bus();
    @(posedge clk); #1;
    $display("reset during read slot=0");
    slot_mode = 8'b01_01_01_01;
    do_read(0, 16'hFFFF);                       // back to init
    do_read(3, 16'hFFFF);

    // A write coincident with reset is discarded.
    active_slot = 2'd1;
    bus.addr = 16'hFFFF; bus.data_in = 8'h12; bus.mreq = 1'b1; bus.wr = 1'b1; bus.req = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_bus();
    @(posedge clk); #1;
    $display("write during reset slot=1 discarded");
    do_read(1, 16'hFFFF);                       // expect ~AA = 55

    // Randomised traffic against the model.
    for (int n = 0; n < 200; n++) begin
      int s;
      int op;
      logic [15:0] a;
      if ($urandom_range(0, 9) == 0) slot_mode = 8'($urandom);
      force_en = ($urandom_range(0, 7) == 0);
      s = $urandom_range(0, NS - 1);
      a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'hFFFF;
      op = $urandom_range(0, 2);
      case (op)
        0: do_write(s, 8'($urandom), a);
        1: do_read(s, a);
        default: check_subslot(s, 16'($urandom));
      endcase
    end
    force_en = 1'b0;
    idle_bus();
    @(posedge clk); #1;

`ifdef SUBSLOT_EXPANDER_WRCNT_EN
    // Saturating write counter.
    slot_mode = 8'b01_01_01_01;
    do_reset({8'hE4, 8'h00, 8'hAA, 8'h55});
    for (int n = 0; n < 300; n++) do_write(3, 8'($urandom), 16'hFFFF);
    check("wr_count3", 32'(wr_count[31:24]), 32'hFF);
    check("wr_count2", 32'(wr_count[23:16]), 32'h00);
    check("wr_count1", 32'(wr_count[15:8]), 32'h00);
    check("wr_count0", 32'(wr_count[7:0]), 32'h00);
`endif

    @(posedge clk); #1;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
